mult_div_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit for the multicycle CPU. It consumes the same operand pair the ALU sees: A from register A and B from the ALU-source-B selector, taken when the B select is 00. It produces the HI/LO result registers read by the mfhi/mflo paths. The control unit issues `start` and holds the FSM in a wait state until `done`.

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_unit_div_core.sv | 56 +++++
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The divider is present only when MULT_DIV_DIV_EN is defined.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // One Booth step or one quotient bit per cycle.
    localparam int MD_STEPS = 32;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Iterative unsigned restoring divider. Works on operand magnitudes and
// produces one quotient bit per step. It is compiled only when
// MULT_DIV_DIV_EN is defined.
`ifdef MULT_DIV_DIV_EN
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // diff[WIDTH] set means the subtraction borrowed, so the remainder is restored.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
    end

    // Remainder/quotient shift register: load on start, one bit per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
`endif

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers.
// Multiply: radix-2 Booth, 32 steps. Divide (MULT_DIV_DIV_EN): restoring
// divide on magnitudes in div_core, signs fixed up when HI/LO are written.
//
// Handshake: start is sampled only in IDLE (with op, a_in, b_in). busy is
// high from the accepting edge until the done cycle. done is a one-cycle
// registered pulse marking HI/LO written (or the op aborted for div-by-zero
// or, without the divider, any div). A new start is taken no earlier than
// the edge that ends the done cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [5:0] LAST_STEP = 6'(MD_STEPS - 1);

    state_t           state;
    logic [5:0]       cnt;
    logic             op_q;
    logic             skip_q;   // finish without writing HI/LO
    logic             dz_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mpl;
    logic             q1;
    logic [WIDTH:0]   bsum;

`ifdef MULT_DIV_DIV_EN
    logic             neg_q;
    logic             neg_r;
    logic             div_load;
    logic             div_step;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dr;

    assign div_load = (state == IDLE) && start && (op == OP_DIV);
    assign div_step = (state == DIV);
    assign dvd_mag  = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign dvs_mag  = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (dq),
        .remainder (dr)
    );
`endif

    // Booth add/subtract in WIDTH+1 bits so the arithmetic shift sees the true
    // sign even when the multiplicand is the most negative value.
    always_comb begin
        bsum = {acc[WIDTH-1], acc};
        case ({mpl[0], q1})
            2'b01:   bsum = {acc[WIDTH-1], acc} + {mcand[WIDTH-1], mcand};
            2'b10:   bsum = {acc[WIDTH-1], acc} - {mcand[WIDTH-1], mcand};
            default: bsum = {acc[WIDTH-1], acc};
        endcase
    end

    // Control FSM, Booth register, sign fix-up and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= OP_MULT;
            skip_q   <= 1'b0;
            dz_q     <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mpl      <= '0;
            q1       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULT_DIV_DIV_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        mcand <= a_in;
                        acc   <= '0;
                        mpl   <= b_in;
                        q1    <= 1'b0;
`ifdef MULT_DIV_DIV_EN
                        neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_r <= a_in[WIDTH-1];
`endif
                        if (op == OP_MULT) begin
                            state  <= MULT;
                            skip_q <= 1'b0;
                            dz_q   <= 1'b0;
`ifdef MULT_DIV_DIV_EN
                        end else if (b_in == '0) begin
                            state  <= FINISH;
                            skip_q <= 1'b1;
                            dz_q   <= 1'b1;
                        end else begin
                            state  <= DIV;
                            skip_q <= 1'b0;
                            dz_q   <= 1'b0;
                        end
`else
                        end else begin
                            state  <= FINISH;
                            skip_q <= 1'b1;
                            dz_q   <= 1'b0;
                        end
`endif
                    end
                end
                MULT: begin
                    acc <= bsum[WIDTH:1];
                    mpl <= {bsum[0], mpl[WIDTH-1:1]};
                    q1  <= mpl[0];
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_STEP) state <= FINISH;
                end
`ifdef MULT_DIV_DIV_EN
                DIV: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_STEP) state <= FINISH;
                end
`endif
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= dz_q;
                    busy     <= 1'b0;
                    state    <= IDLE;
                    if (!skip_q) begin
                        if (op_q == OP_MULT) begin
                            hi <= acc;
                            lo <= mpl;
                        end
`ifdef MULT_DIV_DIV_EN
                        else begin
                            lo <= neg_q ? (~dq + 1'b1) : dq;
                            hi <= neg_r ? (~dr + 1'b1) : dr;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. Expected HI/LO come from plain
// 64-bit signed arithmetic; expected latency from the documented timing.
// Divide expectations follow MULT_DIV_DIV_EN.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int          checks = 0;
  int          errors = 0;

  // Reference model state: architectural HI/LO and the pending op's timing.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_q[$];
  int          exp_lat;
  logic        exp_dz;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Reference model: computes the result from signed arithmetic rules.
  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint q;
    longint r;
    if (o == 1'b0) begin
      p = longint'($signed(a)) * longint'($signed(b));
      m_hi = p[63:32];
      m_lo = p[31:0];
      exp_lat = 33;
      exp_dz = 1'b0;
    end else begin
`ifdef MULT_DIV_DIV_EN
      if (b == 32'd0) begin
        exp_lat = 1;
        exp_dz = 1'b1;
      end else begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        m_lo = q[31:0];
        m_hi = r[31:0];
        exp_lat = 33;
        exp_dz = 1'b0;
      end
`else
      exp_lat = 1;
      exp_dz = 1'b0;
`endif
    end
    exp_q.push_back({m_hi, m_lo});
  endtask

  // Driver: called just after a rising edge; start is taken at the next edge.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    model(o, a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 1'($urandom);
    a_in = $urandom;
    b_in = $urandom;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b done=%b required busy=1 done=0", busy, done);
    end
  endtask

  // Follow one op to its done pulse; poke>0 pulses start at that cycle.
  task automatic check_op(input int poke, input bit chain);
    logic [63:0] e;
    for (int k = 1; k <= exp_lat; k++) begin
      @(posedge clk);
      #1;
      if (k < exp_lat) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || div_zero !== 1'b0) begin
          errors++;
          $display("FAIL inflight k=%0d: done=%b busy=%b div_zero=%b required 0 1 0",
                   k, done, busy, div_zero);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_edge k=%0d: done=%b busy=%b required 1 0", k, done, busy);
        end
        checks++;
        if (div_zero !== exp_dz) begin
          errors++;
          $display("FAIL div_zero: got %b required %b", div_zero, exp_dz);
        end
        checks++;
        if (hi !== e[63:32]) begin
          errors++;
          $display("FAIL hi: got %h required %h", hi, e[63:32]);
        end
        checks++;
        if (lo !== e[31:0]) begin
          errors++;
          $display("FAIL lo: got %h required %h", lo, e[31:0]);
        end
      end
      if (k == poke) begin
        start = 1'b1;
        op = 1'($urandom);
        a_in = $urandom;
        b_in = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    if (!chain) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL after_done: done=%b busy=%b hi=%h lo=%h required 0 0 %h %h",
                 done, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: hi=%h lo=%h busy=%b done=%b dz=%b required all 0",
               hi, lo, busy, done, div_zero);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_mult_directed();
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    check_op(0, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_7x-3: hi=%h lo=%h required ffffffff ffffffeb", hi, lo);
    end
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    check_op(0, 1'b0);
    checks++;
    if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
      errors++;
      $display("FAIL mult_min_sq: hi=%h lo=%h required 40000000 00000000", hi, lo);
    end
  endtask

  task automatic test_div_directed();
    issue(1'b1, 32'd100, 32'd7);
    check_op(0, 1'b0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    check_op(0, 1'b0);
  endtask

  task automatic test_div_zero();
    // 6 * 715827883 = 0x1_00000002 leaves hi=1, lo=2
    issue(1'b0, 32'd6, 32'd715827883);
    check_op(0, 1'b0);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd2) begin
      errors++;
      $display("FAIL preset: hi=%h lo=%h required 1 2", hi, lo);
    end
    issue(1'b1, 32'd5, 32'd0);
    check_op(0, 1'b0);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd2) begin
      errors++;
      $display("FAIL div0_retain: hi=%h lo=%h required 1 2", hi, lo);
    end
  endtask

  task automatic test_start_while_busy();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op(10, 1'b0);
    // start in the FINISH cycle must also be dropped
    issue(1'b0, 32'd12345, 32'hFFFF_0000);
    check_op(32, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b dz=%b required all 0",
               hi, lo, busy, done, div_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: activity seen=%b required 0", seen);
    end
    issue(1'b0, 32'd3, 32'd4);
    check_op(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'hFFFF_FF00, 32'd77);
    check_op(0, 1'b1);
    issue(1'b1, 32'd1000, 32'hFFFF_FFFD);
    check_op(0, 1'b1);
    issue(1'b1, 32'd9, 32'd0);
    check_op(0, 1'b1);
    issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check_op(0, 1'b0);
  endtask

  task automatic test_random();
    logic        o;
    logic [31:0] a;
    logic [31:0] b;
    int          poke;
    for (int n = 0; n < 24; n++) begin
      o = 1'($urandom_range(0, 1));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      issue(o, a, b);
      poke = 0;
      if (exp_lat > 1 && $urandom_range(0, 2) == 0) poke = $urandom_range(1, exp_lat - 1);
      check_op(poke, 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
